fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0).
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: stall  in  1  hazard-unit stall; hold PCF and IF/ID.
REQ-006 SHALL have ports: flush  in  1  hazard-unit flush; IF/ID becomes bubble.
REQ-007 SHALL have ports: PCSrcE  in  1  redirect from execute (taken branch, JAL, JALR).
REQ-008 SHALL have ports: PCTargetE  in  32  redirect address.
REQ-009 SHALL have ports: imem_req  out  1  fetch request, held until imem_ack.
REQ-010 SHALL have ports: imem_addr  out  32  word-aligned fetch address, stable while imem_req=1.
REQ-011 SHALL have ports: imem_ack  in  1  response strobe; imem_rdata valid this cycle.
REQ-012 SHALL have ports: imem_rdata  in  32  fetched instruction.
REQ-013 SHALL have ports: InstrD, PCD, PCPlus4D  out  32 each  IF/ID register contents.
REQ-014 SHALL have ports: ValidD  out  1  IF/ID holds a real instruction.
REQ-015 SHALL have ports: fetch_busy  out  1  high in WAIT or DISCARD.

Function
REQ-016 SHALL keep at most one outstanding request; imem_addr = PCF while in REQ/WAIT.
REQ-017 SHALL implement states REQ (issue imem_req), WAIT (held, no ack yet), DISCARD (drop in-flight response).
REQ-018 SHALL transition REQ->WAIT on no ack; REQ/WAIT stay/return to REQ on ack (PCF advances).
REQ-019 SHALL, on PCSrcE while a request is un-acked, enter DISCARD, latch PCTargetE into PCF, keep old imem_addr until ack.
REQ-020 SHALL, in DISCARD on ack, drop imem_rdata and go to REQ at the latched target.
REQ-021 SHALL, on PCSrcE with no un-acked request, load PCF=PCTargetE; next request uses target.
REQ-022 SHALL prioritise next PC: PCSrcE > early JAL (REQ-031) > PCF+4; adder wraps mod 2^32.
REQ-023 SHALL, on ack while stall=0, flush=0, not DISCARD: load InstrD=imem_rdata, PCD=PCF, PCPlus4D=PCF+4, ValidD=1 next edge.
REQ-024 SHALL load bubble (InstrD=NOP_INSTR, ValidD=0) when no usable ack arrives and stall=0 (fetch latency bubble).
REQ-025 SHALL, on flush, load bubble regardless of stall or ack; flush wins over stall; an acked word in that cycle is discarded.
REQ-026 SHALL, on stall=1 and flush=0, hold IF/ID and PCF; an ack arriving is captured in a 1-entry hold buffer.
REQ-027 SHALL not issue imem_req while the hold buffer is full; buffer drains into IF/ID on first cycle stall=0, before any new ack.
REQ-028 SHALL clear the hold buffer on PCSrcE or flush.
REQ-029 SHALL give 1-cycle best-case latency: ack at edge N -> ValidD=1 after edge N+1.

Reset
REQ-030 SHALL, while rst=1: PCF=RESET_PC, state=REQ, imem_req=0, hold buffer empty, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, fetch_busy=0; first request the cycle after rst falls; reset mid-WAIT abandons the request (imem must also reset).

Configuration
REQ-031 SHALL, with JAL_EARLY_REDIRECT_EN defined, decode accepted words with opcode 7'b1101111 and set next PCF=PCF+sign-extended J-immediate instead of PCF+4; execute-stage JAL redirect still overrides.
REQ-032 SHALL, without JAL_EARLY_REDIRECT_EN, always fetch sequentially except on PCSrcE.

Structure
REQ-033 SHALL place RESET_PC default, NOP_INSTR, OPCODE_JAL and the state enum typedef in shared package pipeline_pkg.
REQ-034 SHALL use one sub-module, if_id_reg (IF/ID register with stall/flush/bubble load).

Verification
REQ-035 SHALL cover: reset, imem_ack every cycle -> addresses 0x0,0x4,0x8; ValidD=1 from second ack edge.
REQ-036 SHALL cover: ack delayed 3 cycles -> imem_addr stable, fetch_busy=1, 3 bubbles in IF/ID.
REQ-037 SHALL cover: PCSrcE=1, PCTargetE=0x100 during WAIT -> DISCARD, stale word dropped, next imem_addr=0x100.
REQ-038 SHALL cover: stall=1 two cycles with ack -> IF/ID held, word buffered, no new req; emitted after stall drops.
REQ-039 SHALL cover: stall=1 and flush=1 together -> InstrD=0x00000013, ValidD=0.
REQ-040 SHALL cover, with JAL_EARLY_REDIRECT_EN: word 0x0080006F at PC 0x0 -> next imem_addr=0x8.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch-stage constants, FSM state type and JAL immediate decode.
//   RESET_PC_DEFAULT - default first fetch address
//   NOP_INSTR        - bubble instruction (addi x0,x0,0)
//   OPCODE_JAL       - major opcode of JAL
//   fetch_state_e    - fetch FSM states
//   j_imm()          - sign-extended J-type immediate
package pipeline_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0] OPCODE_JAL = 7'b1101111;
    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_DISCARD = 2'd2} fetch_state_e;
    function automatic logic [31:0] j_imm(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus.
//   imem_req/imem_addr   - request (master -> slave), held until imem_ack
//   imem_ack/imem_rdata  - response strobe and instruction word (slave -> master)
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush > stall > load > bubble.
//   clk, rst          - clock, synchronous active-high reset
//   stall_i, flush_i  - hold / force bubble
//   load_i            - instr_i/pc_i carry a real instruction this cycle
//   instr_o, pc_o, pc_plus4_o, valid_o - register contents
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);
    logic [31:0] instr_q, instr_d, pc_q, pc_d, pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        bubble, hold;

    always_comb begin
        bubble  = flush_i || (!stall_i && !load_i);
        hold    = !flush_i && stall_i;
        instr_d = bubble ? NOP_INSTR : hold ? instr_q : instr_i;
        valid_d = !bubble && (hold ? valid_q : 1'b1);
        pc_d    = (bubble || hold) ? pc_q : pc_i;
        pc4_d   = (bubble || hold) ? pc4_q : pc_i + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc4_q;
    assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect, discard and stall hold buffer.
//   clk, rst            - clock, synchronous active-high reset
//   stall, flush        - hazard-unit controls for PCF and IF/ID
//   PCSrcE, PCTargetE   - execute-stage redirect
//   imem                - instruction memory bus (fetch_unit_if.master)
//   InstrD, PCD, PCPlus4D, ValidD - IF/ID register contents
//   fetch_busy          - a request is waiting or being discarded
// Build option: define JAL_EARLY_REDIRECT_EN to follow JAL targets at fetch.
module fetch_unit import pipeline_pkg::*; #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         PCSrcE,
    input  logic [31:0]  PCTargetE,
    fetch_unit_if.master imem,
    output logic [31:0]  InstrD,
    output logic [31:0]  PCD,
    output logic [31:0]  PCPlus4D,
    output logic         ValidD,
    output logic         fetch_busy
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pcf_q, pcf_d, addr_q, addr_d, buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d, seq_pc;
    logic         buf_full_q, buf_full_d, ack_ok, consumed, to_buf;

`ifdef JAL_EARLY_REDIRECT_EN
    assign seq_pc = (imem.imem_rdata[6:0] == OPCODE_JAL) ? pcf_q + j_imm(imem.imem_rdata) : pcf_q + 32'd4;
`else
    assign seq_pc = pcf_q + 32'd4;
`endif

    // The request held during WAIT/DISCARD keeps the address it was issued with,
    // even after a redirect has already moved PCF to the target.
    assign imem.imem_req  = !rst && (state_q != S_REQ || !buf_full_q);
    assign imem.imem_addr = {(state_q == S_REQ ? pcf_q[31:2] : addr_q[31:2]), 2'b00};
    assign fetch_busy     = state_q != S_REQ;

    always_comb begin
        ack_ok      = imem.imem_ack && imem.imem_req && state_q != S_DISCARD;
        // A word is consumed (PCF moves past it) when it lands in IF/ID or the hold buffer;
        // a flushed word is not consumed, so its address is fetched again.
        consumed    = ack_ok && !flush && !(stall && PCSrcE);
        to_buf      = consumed && stall;
        pcf_d       = PCSrcE ? PCTargetE : consumed ? seq_pc : pcf_q;
        addr_d      = state_q == S_REQ ? pcf_q : addr_q;
        buf_full_d  = !(flush || PCSrcE) && (buf_full_q ? stall : to_buf);
        buf_instr_d = to_buf ? imem.imem_rdata : buf_instr_q;
        buf_pc_d    = to_buf ? pcf_q : buf_pc_q;
        state_d     = state_q == S_DISCARD ? (imem.imem_ack ? S_REQ : S_DISCARD) :
                      (!imem.imem_req || imem.imem_ack) ? S_REQ :
                      PCSrcE ? S_DISCARD : S_WAIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pcf_q       <= RESET_PC;
            addr_q      <= RESET_PC;
            buf_full_q  <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            addr_q      <= addr_d;
            buf_full_q  <= buf_full_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    // While the buffer is full no request is outstanding, so it drains before any new ack.
    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .flush_i    (flush),
        .load_i     (buf_full_q || ack_ok),
        .instr_i    (buf_full_q ? buf_instr_q : imem.imem_rdata),
        .pc_i       (buf_full_q ? buf_pc_q : pcf_q),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush, pcsrc;
    logic [31:0] target, InstrD, PCD, PCPlus4D;
    logic        ValidD, fetch_busy;
    exp_t        q[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;

    fetch_unit_if imem_bus();

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .PCSrcE     (pcsrc),
        .PCTargetE  (target),
        .imem       (imem_bus),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_word(input logic [31:0] w, input bit expect_it);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = w;
        if (expect_it) q.push_back('{w, imem_bus.imem_addr});
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; pcsrc = 1'b0; target = '0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
        repeat (3) step();
        checks++;
        if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_bus.imem_req); end
        checks++;
        if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b0, 32'h13, 32'h0, 32'h0}) begin
            errors++; $display("FAIL reset_ifid: got v=%0b instr=%h pc=%h pc4=%h want v=0 instr=00000013 pc=0 pc4=0", ValidD, InstrD, PCD, PCPlus4D);
        end
        checks++;
        if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", fetch_busy); end
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL first_req: got req=%0b addr=%h want req=1 addr=0", imem_bus.imem_req, imem_bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_bus.imem_addr !== 32'(i * 4)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, imem_bus.imem_addr, 32'(i * 4)); end
            ack_word(mem_word(imem_bus.imem_addr), 1'b1);
            step();
            checks++;
            if (q.size() == 0) begin errors++; $display("FAIL seq_sb%0d: scoreboard empty", i); end
            else begin
                e = q.pop_front();
                if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, e.instr, e.pc, e.pc + 32'd4}) begin
                    errors++; $display("FAIL seq_ifid%0d: got v=%0b instr=%h pc=%h pc4=%h want v=1 instr=%h pc=%h", i, ValidD, InstrD, PCD, PCPlus4D, e.instr, e.pc);
                end
            end
        end
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_delayed_ack();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({imem_bus.imem_req, imem_bus.imem_addr, fetch_busy, ValidD, InstrD} !== {1'b1, 32'hC, 1'b1, 1'b0, 32'h13}) begin
                errors++; $display("FAIL wait%0d: got req=%0b addr=%h busy=%0b v=%0b instr=%h want req=1 addr=c busy=1 v=0 instr=13", i, imem_bus.imem_req, imem_bus.imem_addr, fetch_busy, ValidD, InstrD);
            end
        end
        ack_word(mem_word(imem_bus.imem_addr), 1'b1);
        step();
        imem_bus.imem_ack = 1'b0;
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL wait_sb: scoreboard empty"); end
        else begin
            e = q.pop_front();
            if ({ValidD, InstrD, PCD, fetch_busy, imem_bus.imem_addr} !== {1'b1, e.instr, e.pc, 1'b0, 32'h10}) begin
                errors++; $display("FAIL wait_done: got v=%0b instr=%h pc=%h busy=%0b addr=%h want v=1 instr=%h pc=%h busy=0 addr=10", ValidD, InstrD, PCD, fetch_busy, imem_bus.imem_addr, e.instr, e.pc);
            end
        end
    endtask

    task automatic test_discard();
        step();
        pcsrc = 1'b1; target = 32'h100;
        step();
        pcsrc = 1'b0;
        checks++;
        if ({fetch_busy, imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 1'b1, 32'h10}) begin
            errors++; $display("FAIL discard_hold: got busy=%0b req=%0b addr=%h want busy=1 req=1 addr=10", fetch_busy, imem_bus.imem_req, imem_bus.imem_addr);
        end
        ack_word(32'hDEAD_BEEF, 1'b0);
        step();
        imem_bus.imem_ack = 1'b0;
        checks++;
        if ({ValidD, InstrD, fetch_busy, imem_bus.imem_addr} !== {1'b0, 32'h13, 1'b0, 32'h100}) begin
            errors++; $display("FAIL discard_drop: got v=%0b instr=%h busy=%0b addr=%h want v=0 instr=13 busy=0 addr=100", ValidD, InstrD, fetch_busy, imem_bus.imem_addr);
        end
        ack_word(mem_word(imem_bus.imem_addr), 1'b1);
        step();
        imem_bus.imem_ack = 1'b0;
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL target_sb: scoreboard empty"); end
        else begin
            e = q.pop_front();
            if ({ValidD, InstrD, PCD} !== {1'b1, e.instr, e.pc}) begin
                errors++; $display("FAIL target_ifid: got v=%0b instr=%h pc=%h want v=1 instr=%h pc=%h", ValidD, InstrD, PCD, e.instr, e.pc);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        ack_word(mem_word(imem_bus.imem_addr), 1'b1);
        step();
        imem_bus.imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({ValidD, PCD, imem_bus.imem_req} !== {1'b1, 32'h100, 1'b0}) begin
                errors++; $display("FAIL stall_hold%0d: got v=%0b pc=%h req=%0b want v=1 pc=100 req=0", i, ValidD, PCD, imem_bus.imem_req);
            end
            if (i == 0) step();
        end
        stall = 1'b0;
        step();
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL stall_sb: scoreboard empty"); end
        else begin
            e = q.pop_front();
            if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, e.instr, e.pc, e.pc + 32'd4}) begin
                errors++; $display("FAIL stall_drain: got v=%0b instr=%h pc=%h pc4=%h want v=1 instr=%h pc=%h", ValidD, InstrD, PCD, PCPlus4D, e.instr, e.pc);
            end
        end
        checks++;
        if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 32'h108}) begin
            errors++; $display("FAIL stall_resume: got req=%0b addr=%h want req=1 addr=108", imem_bus.imem_req, imem_bus.imem_addr);
        end
    endtask

    task automatic test_stall_flush();
        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        checks++;
        if ({InstrD, ValidD} !== {32'h0000_0013, 1'b0}) begin
            errors++; $display("FAIL stall_flush: got instr=%h v=%0b want instr=00000013 v=0", InstrD, ValidD);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_bus.imem_addr !== 32'h108 + 32'(i * 4)) begin
                errors++; $display("FAIL b2b_addr%0d: got %h want %h", i, imem_bus.imem_addr, 32'h108 + 32'(i * 4));
            end
            ack_word(mem_word(imem_bus.imem_addr), 1'b1);
            step();
            checks++;
            if (q.size() == 0) begin errors++; $display("FAIL b2b_sb%0d: scoreboard empty", i); end
            else begin
                e = q.pop_front();
                if ({ValidD, InstrD, PCD} !== {1'b1, e.instr, e.pc}) begin
                    errors++; $display("FAIL b2b_ifid%0d: got v=%0b instr=%h pc=%h want v=1 instr=%h pc=%h", i, ValidD, InstrD, PCD, e.instr, e.pc);
                end
            end
        end
        pcsrc = 1'b1; target = 32'h200;
        ack_word(mem_word(imem_bus.imem_addr), 1'b1);
        step();
        pcsrc = 1'b0; imem_bus.imem_ack = 1'b0;
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL redirect_sb: scoreboard empty"); end
        else begin
            e = q.pop_front();
            if ({ValidD, InstrD, PCD, imem_bus.imem_addr, fetch_busy} !== {1'b1, e.instr, e.pc, 32'h200, 1'b0}) begin
                errors++; $display("FAIL redirect_acked: got v=%0b instr=%h pc=%h addr=%h busy=%0b want v=1 instr=%h pc=%h addr=200 busy=0", ValidD, InstrD, PCD, imem_bus.imem_addr, fetch_busy, e.instr, e.pc);
            end
        end
        step();
        checks++;
        if (ValidD !== 1'b0 || q.size() != 0) begin
            errors++; $display("FAIL drain_end: got v=%0b pending=%0d want v=0 pending=0", ValidD, q.size());
        end
    endtask

`ifdef JAL_EARLY_REDIRECT_EN
    task automatic test_jal_early();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
        ack_word(32'h0080_006F, 1'b1);
        step();
        imem_bus.imem_ack = 1'b0;
        e = q.pop_front();
        checks++;
        if ({ValidD, InstrD, PCD, imem_bus.imem_addr} !== {1'b1, e.instr, e.pc, 32'h8}) begin
            errors++; $display("FAIL jal_early: got v=%0b instr=%h pc=%h addr=%h want v=1 instr=%h pc=%h addr=8", ValidD, InstrD, PCD, imem_bus.imem_addr, e.instr, e.pc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_discard();
        test_stall();
        test_stall_flush();
        test_back_to_back();
`ifdef JAL_EARLY_REDIRECT_EN
        test_jal_early();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end
endmodule
